// File: rtl/csi2_packet_parser_if.sv
// Byte-stream input and parsed-packet outputs of the CSI-2 packet parser.
interface csi2_packet_parser_if;
    logic [7:0]  data_in;
    logic        in_valid;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        hdr_valid;
    logic [7:0]  data_out;
    logic        out_valid;
    logic        out_last;
    logic        frame_start;
    logic        frame_end;
    logic        ecc_corrected;
    logic        ecc_error;
    logic        crc_error;
    logic        pkt_drop;

    // Lane-merger side: supplies bytes, observes parser results.
    modport master (
        output data_in, in_valid,
        input  vc, dt, wc, hdr_valid, data_out, out_valid, out_last,
               frame_start, frame_end, ecc_corrected, ecc_error, crc_error, pkt_drop
    );

    // Parser side.
    modport slave (
        input  data_in, in_valid,
        output vc, dt, wc, hdr_valid, data_out, out_valid, out_last,
               frame_start, frame_end, ecc_corrected, ecc_error, crc_error, pkt_drop
    );
endinterface

// File: rtl/csi2_packet_parser.sv
// CSI-2 packet parser: header ECC check/correction, VC filtering, payload
// forwarding with one cycle of latency, and payload CRC-16 checking.
module csi2_packet_parser #(
    parameter logic [3:0]  VC_MASK = 4'b1111,
    parameter logic [15:0] MAX_WC  = 16'd4096,
    parameter bit          CRC_EN  = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    csi2_packet_parser_if.slave bus
);
    typedef enum logic [1:0] {HDR, PAYLOAD, CRC0, CRC1} state_t;

    // Syndrome produced by a single flipped bit of ph, indexed by bit position.
    localparam logic [0:23][5:0] ECC_COL = {
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    function automatic logic [5:0] ecc_calc(input logic [23:0] ph);
        logic [5:0] p;
        p = 6'h00;
        for (int i = 0; i < 24; i++)
            if (ph[i]) p = p ^ ECC_COL[i];
        return p;
    endfunction

    // Reflected CRC-16 (0x8408), one byte processed LSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    state_t      state, state_nxt;
    logic [1:0]  hdr_cnt;
    logic [7:0]  di_byte, wcl_byte, wch_byte;
    logic [15:0] byte_cnt;
    logic [15:0] crc;
    logic [7:0]  crc_lo;
    logic        drop;

    logic [1:0]  cur_vc;
    logic [5:0]  cur_dt;
    logic [15:0] cur_wc;
    logic [7:0]  pay_byte;
    logic        hdr_pulse, pay_valid, pay_last, fs_pulse, fe_pulse;
    logic        corr_pulse, eerr_pulse, crc_pulse, drop_pulse;

    logic [23:0] ph_rx, ph_fix;
    logic [5:0]  syndrome;
    logic        ecc_corr, hdr_good;
    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        hdr_long, hdr_drop;

    // Header decode: syndrome, single-bit correction and packet classification.
    always_comb begin
        ph_rx    = {wch_byte, wcl_byte, di_byte};
        syndrome = bus.data_in[5:0] ^ ecc_calc(ph_rx);
        ph_fix   = ph_rx;
        ecc_corr = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (syndrome == ECC_COL[i]) begin
                ph_fix[i] = ~ph_rx[i];
                ecc_corr  = 1'b1;
            end
        end
        // A flipped ECC bit leaves the header itself intact.
        for (int j = 0; j < 6; j++)
            if (syndrome == (6'b1 << j)) ecc_corr = 1'b1;
        hdr_good = (syndrome == 6'h00) || ecc_corr;
        hdr_vc   = ph_fix[7:6];
        hdr_dt   = ph_fix[5:0];
        hdr_wc   = ph_fix[23:8];
        hdr_long = (hdr_dt >= 6'h10);
        hdr_drop = !VC_MASK[hdr_vc] || (hdr_wc > MAX_WC);
    end

    // Next-state logic; only valid input bytes move the FSM.
    always_comb begin
        state_nxt = state;
        if (bus.in_valid) begin
            case (state)
                HDR:     if (hdr_cnt == 2'd3 && hdr_good && hdr_long)
                             state_nxt = (hdr_wc == 16'd0) ? CRC0 : PAYLOAD;
                PAYLOAD: if (byte_cnt == 16'd1) state_nxt = CRC0;
                CRC0:    state_nxt = CRC1;
                default: state_nxt = HDR;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= HDR;
        else        state <= state_nxt;
    end

    // Header capture, payload forwarding, CRC accumulation and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_cnt    <= 2'd0;
            di_byte    <= 8'h00;
            wcl_byte   <= 8'h00;
            wch_byte   <= 8'h00;
            byte_cnt   <= 16'd0;
            crc        <= 16'hFFFF;
            crc_lo     <= 8'h00;
            drop       <= 1'b0;
            cur_vc     <= 2'd0;
            cur_dt     <= 6'd0;
            cur_wc     <= 16'd0;
            pay_byte   <= 8'h00;
            hdr_pulse  <= 1'b0;
            pay_valid  <= 1'b0;
            pay_last   <= 1'b0;
            fs_pulse   <= 1'b0;
            fe_pulse   <= 1'b0;
            corr_pulse <= 1'b0;
            eerr_pulse <= 1'b0;
            crc_pulse  <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            hdr_pulse  <= 1'b0;
            pay_valid  <= 1'b0;
            pay_last   <= 1'b0;
            fs_pulse   <= 1'b0;
            fe_pulse   <= 1'b0;
            corr_pulse <= 1'b0;
            eerr_pulse <= 1'b0;
            crc_pulse  <= 1'b0;
            drop_pulse <= 1'b0;
            if (bus.in_valid) begin
                case (state)
                    HDR: begin
                        case (hdr_cnt)
                            2'd0:    di_byte  <= bus.data_in;
                            2'd1:    wcl_byte <= bus.data_in;
                            2'd2:    wch_byte <= bus.data_in;
                            default: ;
                        endcase
                        hdr_cnt <= hdr_cnt + 2'd1;
                        if (hdr_cnt == 2'd3) begin
                            hdr_cnt <= 2'd0;
                            if (hdr_good) begin
                                cur_vc     <= hdr_vc;
                                cur_dt     <= hdr_dt;
                                cur_wc     <= hdr_wc;
                                hdr_pulse  <= 1'b1;
                                corr_pulse <= ecc_corr;
                                fs_pulse   <= (hdr_dt == 6'h00) && VC_MASK[hdr_vc];
                                fe_pulse   <= (hdr_dt == 6'h01) && VC_MASK[hdr_vc];
                                drop_pulse <= hdr_long && hdr_drop;
                                drop       <= hdr_drop;
                                byte_cnt   <= hdr_wc;
                                crc        <= 16'hFFFF;
                            end else begin
                                eerr_pulse <= 1'b1;
                            end
                        end
                    end
                    PAYLOAD: begin
                        byte_cnt <= byte_cnt - 16'd1;
                        if (!drop) begin
                            pay_byte  <= bus.data_in;
                            pay_valid <= 1'b1;
                            pay_last  <= (byte_cnt == 16'd1);
                            crc       <= crc_byte(crc, bus.data_in);
                        end
                    end
                    CRC0: crc_lo <= bus.data_in;
                    default: crc_pulse <= CRC_EN && !drop && ({bus.data_in, crc_lo} != crc);
                endcase
            end
        end
    end

    assign bus.vc            = cur_vc;
    assign bus.dt            = cur_dt;
    assign bus.wc            = cur_wc;
    assign bus.hdr_valid     = hdr_pulse;
    assign bus.data_out      = pay_byte;
    assign bus.out_valid     = pay_valid;
    assign bus.out_last      = pay_last;
    assign bus.frame_start   = fs_pulse;
    assign bus.frame_end     = fe_pulse;
    assign bus.ecc_corrected = corr_pulse;
    assign bus.ecc_error     = eerr_pulse;
    assign bus.crc_error     = crc_pulse;
    assign bus.pkt_drop      = drop_pulse;
endmodule
